// File: rtl/spi_shift_engine_if.sv
// ---------------------------------------------------------------------------
// spi_shift_engine_if
//
// Bundles the control, strobe, serial and status signals of spi_shift_engine.
// clk and rst are not part of the bundle; they stay plain module ports.
//
//   start       frame request (one cycle)
//   tx_data     transmit word, right-aligned
//   len         frame length: 00=8, 01=16, 10=24, 11=32 bits
//   cpha        SPI clock phase for the frame
//   abort       synchronous frame cancel
//   edge_lead   SCLK leading-edge strobe from the clock generator
//   edge_trail  SCLK trailing-edge strobe from the clock generator
//   in          serial data from the follower (MISO)
//   out         serial data to the follower (MOSI)
//   cs          chip select, active-low
//   sclk_run    enable to the clock generator
//   busy        frame in progress
//   done        one-cycle frame-complete pulse
//   rx_data     received word, right-aligned
//
// Modports: master drives requests/strobes/MISO, slave is the shift engine.
// ---------------------------------------------------------------------------
interface spi_shift_engine_if;
    logic        start;
    logic [31:0] tx_data;
    logic [1:0]  len;
    logic        cpha;
    logic        abort;
    logic        edge_lead;
    logic        edge_trail;
    logic        in;
    logic        out;
    logic        cs;
    logic        sclk_run;
    logic        busy;
    logic        done;
    logic [31:0] rx_data;

    modport master (
        output start, tx_data, len, cpha, abort, edge_lead, edge_trail, in,
        input  out, cs, sclk_run, busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, len, cpha, abort, edge_lead, edge_trail, in,
        output out, cs, sclk_run, busy, done, rx_data
    );
endinterface

// File: rtl/spi_shift_engine.sv
// ---------------------------------------------------------------------------
// spi_shift_engine
//
// SPI controller shift engine. Sequences one frame of 8/16/24/32 bits,
// MSB first, against edge strobes supplied by an external SCLK generator.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   spi_shift_engine_if.slave (see interface file for signal list)
//
// Frame sequence: IDLE -> SETUP (1 cycle) -> SHIFT (until the trailing
// edge that completes the last period) -> HOLD (1 cycle) -> FINISH (1 cycle,
// done pulse) -> IDLE. abort in SETUP/SHIFT/HOLD returns to IDLE directly.
// ---------------------------------------------------------------------------
module spi_shift_engine #(
    parameter int unsigned MAX_BITS = 32  // fixed at 32 in this revision
) (
    input  logic                clk,
    input  logic                rst,
    spi_shift_engine_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StFinish
    } state_e;

    state_e                state_q, state_d;
    logic [MAX_BITS-1:0]   tx_sh_q, tx_sh_d;     // transmit bits, MSB-aligned
    logic [MAX_BITS-1:0]   rx_sh_q, rx_sh_d;     // receive shift register
    logic [MAX_BITS-1:0]   rx_data_q, rx_data_d;
    logic [5:0]            nbits_q, nbits_d;
    logic [5:0]            period_q, period_d;
    logic                  cpha_q, cpha_d;
    logic                  out_q, out_d;

    logic [5:0]            start_nbits;
    logic [MAX_BITS-1:0]   start_aligned;
    logic [MAX_BITS-1:0]   rx_mask;
    logic [5:0]            period_inc;
    logic                  last_period;

    // nbits = 8 * (len + 1); max 32 fits in 6 bits.
    assign start_nbits   = {1'b0, bus.len, 3'b000} + 6'd8;
    // Left-align the selected length so the next bit to send is always bit MSB.
    assign start_aligned = bus.tx_data << (6'(MAX_BITS) - start_nbits);
    assign rx_mask       = {MAX_BITS{1'b1}} >> (6'(MAX_BITS) - nbits_q);
    assign period_inc    = period_q + 6'd1;
    assign last_period   = (period_inc == nbits_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        nbits_d   = nbits_q;
        period_d  = period_q;
        cpha_d    = cpha_q;
        out_d     = out_q;

        unique case (state_q)
            StIdle: begin
                out_d = 1'b0;
                if (bus.start) begin
                    state_d  = StSetup;
                    nbits_d  = start_nbits;
                    cpha_d   = bus.cpha;
                    period_d = 6'd0;
                    rx_sh_d  = '0;
                    if (bus.cpha) begin
                        // First bit goes out on the first leading edge.
                        tx_sh_d = start_aligned;
                    end else begin
                        // First bit must be stable before the first leading edge.
                        out_d   = start_aligned[MAX_BITS-1];
                        tx_sh_d = start_aligned << 1;
                    end
                end
            end

            StSetup: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    out_d   = 1'b0;
                end else begin
                    state_d = StShift;
                end
            end

            StShift: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    out_d   = 1'b0;
                end else if (bus.edge_lead) begin
                    // Leading edge wins over a coincident trailing edge.
                    if (cpha_q) begin
                        out_d   = tx_sh_q[MAX_BITS-1];
                        tx_sh_d = tx_sh_q << 1;
                    end else begin
                        rx_sh_d = {rx_sh_q[MAX_BITS-2:0], bus.in};
                    end
                end else if (bus.edge_trail) begin
                    period_d = period_inc;
                    if (cpha_q) begin
                        rx_sh_d = {rx_sh_q[MAX_BITS-2:0], bus.in};
                    end else if (!last_period) begin
                        // No bit left after the final period; out keeps bit 0.
                        out_d   = tx_sh_q[MAX_BITS-1];
                        tx_sh_d = tx_sh_q << 1;
                    end
                    if (last_period) begin
                        state_d = StHold;
                    end
                end
            end

            StHold: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    out_d   = 1'b0;
                end else begin
                    state_d   = StFinish;
                    // Loaded on entry so rx_data is valid alongside done.
                    rx_data_d = rx_sh_q & rx_mask;
                end
            end

            StFinish: begin
                state_d = StIdle;
                out_d   = 1'b0;
            end

            default: begin
                state_d = StIdle;
                out_d   = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            nbits_q   <= '0;
            period_q  <= '0;
            cpha_q    <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            nbits_q   <= nbits_d;
            period_q  <= period_d;
            cpha_q    <= cpha_d;
            out_q     <= out_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from state so reset acts on them immediately)
    // -----------------------------------------------------------------------
    logic in_frame;
    assign in_frame = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);

    assign bus.cs       = ~in_frame;
    assign bus.busy     = in_frame;
    assign bus.sclk_run = (state_q == StShift);
    assign bus.done     = (state_q == StFinish);
    assign bus.out      = out_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_shift_engine
//
// Self-checking bench for spi_shift_engine. The bench plays the clock
// generator (edge strobes) and the follower (MISO). Expected MOSI bits and
// the received word are derived from the frame rules: bit nbits-1-k is sent
// in period k, and received bits accumulate MSB first into the low nbits.
// ---------------------------------------------------------------------------
module tb_spi_shift_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_shift_engine_if ifc ();

    logic loop_en = 1'b0;
    logic in_drv  = 1'b0;
    assign ifc.in = loop_en ? ifc.out : in_drv;

    spi_shift_engine #(.MAX_BITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;

    always @(negedge clk) if (ifc.done === 1'b1) done_cnt++;

    // Current frame model
    bit [31:0] f_tx;
    int        f_n;
    bit        f_cpha;
    int        f_mode;     // 0 loopback, 1 MISO tied high, 2 random MISO
    bit [31:0] f_rx_exp;
    int        f_done0;

    task automatic frame_start(input bit [31:0] tx, input bit [1:0] l, input bit c,
                               input int mode);
        f_tx = tx; f_n = 8 * (int'(l) + 1); f_cpha = c; f_mode = mode;
        f_rx_exp = '0; f_done0 = done_cnt;
        loop_en = (mode == 0);
        ifc.start = 1'b1; ifc.tx_data = tx; ifc.len = l; ifc.cpha = c;
        @(negedge clk);
        ifc.start = 1'b0; ifc.abort = 1'b0;
        ifc.tx_data = $urandom; ifc.len = 2'($urandom); ifc.cpha = 1'($urandom);
        tests_run++;
        if (ifc.cs !== 1'b0 || ifc.busy !== 1'b1 || ifc.sclk_run !== 1'b0) begin
            tests_failed++;
            $display("FAIL setup_ctl: cs/busy/sclk_run got %b%b%b want 010",
                     ifc.cs, ifc.busy, ifc.sclk_run);
        end
        tests_run++;
        if (ifc.out !== (c ? 1'b0 : tx[f_n-1])) begin
            tests_failed++;
            $display("FAIL setup_out: got %b want %b", ifc.out, c ? 1'b0 : tx[f_n-1]);
        end
        @(negedge clk);
        tests_run++;
        if (ifc.sclk_run !== 1'b1 || ifc.cs !== 1'b0) begin
            tests_failed++;
            $display("FAIL shift_entry: sclk_run=%b cs=%b want 1,0", ifc.sclk_run, ifc.cs);
        end
    endtask

    task automatic frame_period(input int k, input bit dual);
        bit ib;
        bit exp_out;
        exp_out = f_tx[f_n-1-k];
        repeat ($urandom_range(0, 1)) @(negedge clk);
        if (!f_cpha) begin
            tests_run++;
            if (ifc.out !== exp_out) begin
                tests_failed++;
                $display("FAIL out_bit%0d: got %b want %b", k, ifc.out, exp_out);
            end
        end
        ib = (f_mode == 0) ? exp_out : (f_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (!f_cpha) in_drv = ib;
        ifc.edge_lead = 1'b1; ifc.edge_trail = dual;
        @(negedge clk);
        ifc.edge_lead = 1'b0; ifc.edge_trail = 1'b0;
        if (f_cpha) begin
            tests_run++;
            if (ifc.out !== exp_out) begin
                tests_failed++;
                $display("FAIL out_bit%0d: got %b want %b", k, ifc.out, exp_out);
            end
            in_drv = ib;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tests_run++;
        if (ifc.done !== 1'b0 || ifc.sclk_run !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_period%0d: done=%b sclk_run=%b want 0,1", k, ifc.done,
                     ifc.sclk_run);
        end
        ifc.edge_trail = 1'b1;
        @(negedge clk);
        ifc.edge_trail = 1'b0;
        f_rx_exp = {f_rx_exp[30:0], ib};
    endtask

    task automatic frame_tail();
        tests_run++;
        if (ifc.cs !== 1'b0 || ifc.sclk_run !== 1'b0 || ifc.busy !== 1'b1 ||
            ifc.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_ctl: cs/sclk_run/busy/done got %b%b%b%b want 0010",
                     ifc.cs, ifc.sclk_run, ifc.busy, ifc.done);
        end
        tests_run++;
        if (ifc.out !== f_tx[0]) begin
            tests_failed++;
            $display("FAIL hold_out: got %b want %b", ifc.out, f_tx[0]);
        end
        @(negedge clk);
        tests_run++;
        if (ifc.done !== 1'b1 || ifc.cs !== 1'b1 || ifc.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL finish_ctl: done/cs/busy got %b%b%b want 110",
                     ifc.done, ifc.cs, ifc.busy);
        end
        tests_run++;
        if (ifc.rx_data !== f_rx_exp) begin
            tests_failed++;
            $display("FAIL rx_data: got %h want %h", ifc.rx_data, f_rx_exp);
        end
        @(negedge clk);
        tests_run++;
        if (ifc.done !== 1'b0 || ifc.out !== 1'b0 || ifc.rx_data !== f_rx_exp) begin
            tests_failed++;
            $display("FAIL idle_after: done=%b out=%b rx=%h want 0,0,%h",
                     ifc.done, ifc.out, ifc.rx_data, f_rx_exp);
        end
        tests_run++;
        if (done_cnt !== f_done0 + 1) begin
            tests_failed++;
            $display("FAIL done_count: got %0d want %0d", done_cnt - f_done0, 1);
        end
    endtask

    task automatic run_frame(input bit [31:0] tx, input bit [1:0] l, input bit c,
                             input int mode, input int dual_k);
        frame_start(tx, l, c, mode);
        for (int k = 0; k < f_n; k++) frame_period(k, k == dual_k);
        frame_tail();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        tests_run++;
        if (ifc.cs !== 1'b1 || ifc.out !== 1'b0 || ifc.sclk_run !== 1'b0 ||
            ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.rx_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: cs=%b out=%b run=%b busy=%b done=%b rx=%h",
                     ifc.cs, ifc.out, ifc.sclk_run, ifc.busy, ifc.done, ifc.rx_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // Start in the very first cycle after reset release.
        run_frame(32'h0000_00A5, 2'b00, 1'b0, 0, -1);
    endtask

    task automatic test_vectors();
        run_frame(32'h0000_00A5, 2'b00, 1'b0, 0, -1);
        run_frame(32'hDEAD_BEEF, 2'b11, 1'b1, 1, -1);
        tests_run++;
        if (ifc.rx_data !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL vec_ones: got %h want ffffffff", ifc.rx_data);
        end
        run_frame(32'hFFFF_1234, 2'b01, 1'b0, 0, -1);
        tests_run++;
        if (ifc.rx_data !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL vec_len16: got %h want 00001234", ifc.rx_data);
        end
        run_frame(32'hFFFF_1234, 2'b01, 1'b1, 0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            bit [1:0] l;
            l = 2'($urandom);
            run_frame($urandom, l, 1'($urandom), (i % 2 == 0) ? 2 : 0,
                      int'($urandom_range(0, 8 * (int'(l) + 1) - 1)));
        end
    endtask

    task automatic test_abort();
        bit [31:0] prior;
        int        d0;
        run_frame(32'h0000_5A3C, 2'b01, 1'b0, 0, -1);
        prior = ifc.rx_data;
        // Abort in SHIFT after 5 trailing edges, with a coincident lead strobe.
        frame_start(32'h0000_C3A1, 2'b01, 1'($urandom), 2);
        d0 = f_done0;
        for (int k = 0; k < 5; k++) frame_period(k, 1'b0);
        ifc.abort = 1'b1; ifc.edge_lead = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0; ifc.edge_lead = 1'b0;
        tests_run++;
        if (ifc.cs !== 1'b1 || ifc.sclk_run !== 1'b0 || ifc.busy !== 1'b0 ||
            ifc.out !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_shift: cs/run/busy/out got %b%b%b%b want 1000",
                     ifc.cs, ifc.sclk_run, ifc.busy, ifc.out);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt !== d0 || ifc.rx_data !== prior) begin
            tests_failed++;
            $display("FAIL abort_nodone: done pulses %0d rx=%h want 0,%h",
                     done_cnt - d0, ifc.rx_data, prior);
        end
        // Abort during SETUP.
        ifc.start = 1'b1; ifc.tx_data = 32'h0000_00FF; ifc.len = 2'b00;
        @(negedge clk);
        ifc.start = 1'b0; ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        tests_run++;
        if (ifc.cs !== 1'b1 || ifc.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_setup: cs=%b busy=%b want 1,0", ifc.cs, ifc.busy);
        end
        // Abort during HOLD.
        frame_start(32'h0000_0081, 2'b00, 1'b1, 0);
        d0 = f_done0;
        for (int k = 0; k < f_n; k++) frame_period(k, 1'b0);
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ifc.cs !== 1'b1 || done_cnt !== d0 || ifc.rx_data !== prior) begin
            tests_failed++;
            $display("FAIL abort_hold: cs=%b done pulses %0d rx=%h want 1,0,%h",
                     ifc.cs, done_cnt - d0, ifc.rx_data, prior);
        end
        // abort together with start in IDLE is ignored; frame completes.
        ifc.abort = 1'b1;
        run_frame(32'h0000_B00C, 2'b01, 1'b0, 0, -1);
        run_frame($urandom, 2'b01, 1'b1, 2, -1);
    endtask

    task automatic test_ignore();
        for (int i = 0; i < 6; i++) begin
            ifc.edge_lead = 1'($urandom); ifc.edge_trail = 1'($urandom);
            @(negedge clk);
        end
        ifc.edge_lead = 1'b0; ifc.edge_trail = 1'b0;
        tests_run++;
        if (ifc.cs !== 1'b1 || ifc.out !== 1'b0 || ifc.busy !== 1'b0 ||
            ifc.sclk_run !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_edges: cs/out/busy/run got %b%b%b%b want 1000",
                     ifc.cs, ifc.out, ifc.busy, ifc.sclk_run);
        end
        frame_start(32'h0000_6E19, 2'b01, 1'b0, 0);
        for (int k = 0; k < 3; k++) frame_period(k, 1'b0);
        ifc.start = 1'b1; ifc.tx_data = 32'hFFFF_FFFF; ifc.len = 2'b00; ifc.cpha = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        tests_run++;
        if (ifc.busy !== 1'b1 || ifc.sclk_run !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_in_shift: busy=%b run=%b want 1,1", ifc.busy, ifc.sclk_run);
        end
        for (int k = 3; k < f_n; k++) frame_period(k, 1'b0);
        frame_tail();
    endtask

    task automatic test_async_reset();
        run_frame(32'h0000_0071, 2'b00, 1'b0, 0, -1);
        frame_start($urandom, 2'b11, 1'b0, 0);
        for (int k = 0; k < 4; k++) frame_period(k, 1'b0);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (ifc.cs !== 1'b1 || ifc.sclk_run !== 1'b0 || ifc.rx_data !== 32'h0 ||
            ifc.busy !== 1'b0 || ifc.out !== 1'b0 || ifc.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: cs=%b run=%b rx=%h busy=%b out=%b done=%b",
                     ifc.cs, ifc.sclk_run, ifc.rx_data, ifc.busy, ifc.out, ifc.done);
        end
        @(negedge clk);
        rst = 1'b1;
        run_frame(32'h00C0_FFEE, 2'b10, 1'b1, 0, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            run_frame($urandom, 2'($urandom), 1'($urandom), 2, -1);
        end
    endtask

    initial begin
        ifc.start = 1'b0; ifc.tx_data = '0; ifc.len = '0; ifc.cpha = 1'b0;
        ifc.abort = 1'b0; ifc.edge_lead = 1'b0; ifc.edge_trail = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_abort();
        test_ignore();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
